// File: rtl/write_back_pkg.sv
// Shared definitions for the write-back stage: write-flag bit positions and FSM state encodings.
package write_back_pkg;

   localparam int WF_BITS = 6;

   localparam int WF_GPR_WE = 0;
   localparam int WF_FPR_WE = 1;
   localparam int WF_LOAD   = 2;
   localparam int WF_STORE  = 3;
   localparam int WF_IN     = 4;
   localparam int WF_OUT    = 5;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_R   = 3'd1,
      ST_WAIT_B   = 3'd2,
      ST_WAIT_IN  = 3'd3,
      ST_WAIT_OUT = 3'd4,
      ST_COMMIT   = 3'd5
   } wb_state_t;

endpackage

// File: rtl/write_back.sv
// Final pipeline stage: waits for the memory/UART transaction started by execute,
// then commits the selected result to the GPR/FPR file and loads the PC.
module write_back
   import write_back_pkg::*;
#(
   parameter int INSTR_ADDR_WIDTH = 14,
   parameter int WF_WIDTH         = WF_BITS
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        w_valid,
   input  logic [INSTR_ADDR_WIDTH-1:0] W_pc_incr,
   input  logic                        W_jmp_en,
   input  logic [INSTR_ADDR_WIDTH-1:0] W_jmp_addr,
   input  logic [4:0]                  W_rd_addr,
   input  logic [WF_WIDTH-1:0]         W_write_flags,
   input  logic [31:0]                 W_rd,
   input  logic                        AXI_RVALID,
   input  logic                        AXI_RREADY,
   input  logic [31:0]                 AXI_RDATA,
   input  logic                        AXI_BVALID,
   input  logic                        AXI_BREADY,
   input  logic                        UART_INPUT_TVALID,
   input  logic                        UART_INPUT_TREADY,
   input  logic [7:0]                  UART_INPUT_TDATA,
   input  logic                        UART_OUTPUT_TVALID,
   input  logic                        UART_OUTPUT_TREADY,
   output logic                        gpr_we,
   output logic                        fpr_we,
   output logic [4:0]                  rf_waddr,
   output logic [31:0]                 rf_wdata,
   output logic                        pc_we,
   output logic [INSTR_ADDR_WIDTH-1:0] next_pc,
   output logic                        wb_done,
   output logic                        busy
);

   wb_state_t                   r_state;
   wb_state_t                   w_state_next;
   logic [4:0]                  r_rd_addr;
   logic [WF_WIDTH-1:0]         r_flags;
   logic [31:0]                 r_data;
   logic [31:0]                 w_data_next;
   logic [INSTR_ADDR_WIDTH-1:0] r_pc;

   logic                        r_gpr_we, r_fpr_we, r_pc_we, r_wb_done;
   logic [4:0]                  r_rf_waddr;
   logic [31:0]                 r_rf_wdata;
   logic [INSTR_ADDR_WIDTH-1:0] r_next_pc;

   logic                        w_gpr_we_next, w_fpr_we_next, w_commit;

   logic w_hs_r, w_hs_b, w_hs_in, w_hs_out, w_accept;
   assign w_hs_r   = AXI_RVALID & AXI_RREADY;
   assign w_hs_b   = AXI_BVALID & AXI_BREADY;
   assign w_hs_in  = UART_INPUT_TVALID & UART_INPUT_TREADY;
   assign w_hs_out = UART_OUTPUT_TVALID & UART_OUTPUT_TREADY;
   assign w_accept = (r_state == ST_IDLE) && w_valid;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic; a handshake seen together with w_valid skips the wait state
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_valid) begin
               if (W_write_flags[WF_LOAD])
                  w_state_next = w_hs_r ? ST_COMMIT : ST_WAIT_R;
               else if (W_write_flags[WF_STORE])
                  w_state_next = w_hs_b ? ST_COMMIT : ST_WAIT_B;
               else if (W_write_flags[WF_IN])
                  w_state_next = w_hs_in ? ST_COMMIT : ST_WAIT_IN;
               else if (W_write_flags[WF_OUT])
                  w_state_next = w_hs_out ? ST_COMMIT : ST_WAIT_OUT;
               else
                  w_state_next = ST_COMMIT;
            end
         end
         ST_WAIT_R:   if (w_hs_r)   w_state_next = ST_COMMIT;
         ST_WAIT_B:   if (w_hs_b)   w_state_next = ST_COMMIT;
         ST_WAIT_IN:  if (w_hs_in)  w_state_next = ST_COMMIT;
         ST_WAIT_OUT: if (w_hs_out) w_state_next = ST_COMMIT;
         ST_COMMIT:   w_state_next = ST_IDLE;
         default:     w_state_next = ST_IDLE;
      endcase
   end

   // Data select: execute result, load data or received UART byte
   always_comb begin
      w_data_next = r_data;
      if (w_accept) begin
         if (W_write_flags[WF_LOAD]) begin
            w_data_next = w_hs_r ? AXI_RDATA : W_rd;
         end else if (!W_write_flags[WF_STORE] && W_write_flags[WF_IN] && w_hs_in) begin
            w_data_next = {24'b0, UART_INPUT_TDATA};
         end else begin
            w_data_next = W_rd;
         end
      end else if (r_state == ST_WAIT_R && w_hs_r) begin
         w_data_next = AXI_RDATA;
      end else if (r_state == ST_WAIT_IN && w_hs_in) begin
         w_data_next = {24'b0, UART_INPUT_TDATA};
      end
   end

   // Output logic; GPR wins when both write flags are set, x0 is never written
   always_comb begin
      w_commit      = (r_state == ST_COMMIT);
      w_gpr_we_next = w_commit && r_flags[WF_GPR_WE] && (r_rd_addr != 5'd0);
      w_fpr_we_next = w_commit && r_flags[WF_FPR_WE] && !r_flags[WF_GPR_WE];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_addr  <= '0;
         r_flags    <= '0;
         r_data     <= '0;
         r_pc       <= '0;
         r_gpr_we   <= 1'b0;
         r_fpr_we   <= 1'b0;
         r_pc_we    <= 1'b0;
         r_wb_done  <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
         r_next_pc  <= '0;
      end else begin
         r_data    <= w_data_next;
         if (w_accept) begin
            r_rd_addr <= W_rd_addr;
            r_flags   <= W_write_flags;
            r_pc      <= W_jmp_en ? W_jmp_addr : W_pc_incr;
         end
         r_gpr_we  <= w_gpr_we_next;
         r_fpr_we  <= w_fpr_we_next;
         r_pc_we   <= w_commit;
         r_wb_done <= w_commit;
         if (w_commit) begin
            r_rf_waddr <= r_rd_addr;
            r_rf_wdata <= r_data;
            r_next_pc  <= r_pc;
         end
      end
   end

   // A new instruction while busy is dropped; flag it in simulation
   assert property (@(posedge clk) disable iff (!rst_n) !(w_valid && (r_state != ST_IDLE)));

   assign gpr_we   = r_gpr_we;
   assign fpr_we   = r_fpr_we;
   assign rf_waddr = r_rf_waddr;
   assign rf_wdata = r_rf_wdata;
   assign pc_we    = r_pc_we;
   assign next_pc  = r_next_pc;
   assign wb_done  = r_wb_done;
   assign busy     = (r_state != ST_IDLE);

endmodule
